// File: rtl/rr_arbiter_16x4.sv
// Round-robin arbiter for 16 requesters with registered one-hot and encoded grants.
// A grant is held while its owner keeps requesting, up to MAX_HOLD consecutive cycles.
module rr_arbiter_16x4 #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] req,
    output logic [15:0] gnt,
    output logic [3:0]  gnt_id,
    output logic        gnt_valid
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

    logic [0:0]  state_q, state_d;
    logic [3:0]  ptr_q, ptr_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  owner_q, owner_d;
    logic [15:0] gnt_q, gnt_d;
    logic        release_c;
    logic [3:0]  next_start_c;

    // First requesting index found scanning circularly upward from start.
    function automatic logic [3:0] pick(input logic [3:0] start, input logic [15:0] r);
        logic [3:0] idx;
        logic       found;
        pick  = start;
        found = 1'b0;
        for (int i = 0; i < 16; i++) begin
            idx = start + 4'(i);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    endfunction

    // NOTE: every signal gets a default at the top so no path leaves it unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        release_c    = !en || !req[owner_q] || (cnt_q == MAX_HOLD_C);
        next_start_c = owner_q + 4'd1;

        case (state_q)
            IDLE: begin
                if (en && |req) begin
                    owner_d = pick(ptr_q, req);
                    cnt_d   = 8'd1;
                    state_d = BUSY;
                end
            end
            default: begin
                if (!release_c) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    ptr_d = next_start_c;
                    if (en && |req) begin
                        owner_d = pick(next_start_c, req);
                        cnt_d   = 8'd1;
                    end else begin
                        owner_d = 4'd0;
                        cnt_d   = 8'd0;
                        state_d = IDLE;
                    end
                end
            end
        endcase

        gnt_d = (state_d == BUSY) ? (16'd1 << owner_d) : 16'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= 4'd0;
            cnt_q   <= 8'd0;
            owner_q <= 4'd0;
            gnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = owner_q;
    assign gnt_valid = (state_q == BUSY);

endmodule
